// File: rtl/pong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pong_pkg: shared geometry, start positions and game state type for Pong.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pong_pkg;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int BORDER      = 8;
    localparam int BALL_SIZE   = 8;
    localparam int PAD_W       = 8;
    localparam int PAD_H       = 64;
    localparam int PAD_L_X     = 16;
    localparam int PAD_R_X     = SCREEN_W - PAD_L_X - PAD_W;

    localparam int BALL_X_MIN  = BORDER;
    localparam int BALL_X_MAX  = SCREEN_W - BORDER - BALL_SIZE;
    localparam int BALL_Y_MIN  = BORDER;
    localparam int BALL_Y_MAX  = SCREEN_H - BORDER - BALL_SIZE;
    localparam int PAD_Y_MIN   = BORDER;
    localparam int PAD_Y_MAX   = SCREEN_H - BORDER - PAD_H;

    // Ball x at which it touches the inner face of each paddle
    localparam int PAD_L_HIT_X = PAD_L_X + PAD_W;
    localparam int PAD_R_HIT_X = PAD_R_X - BALL_SIZE;

    localparam int BALL_X_START = SCREEN_W / 2 - BALL_SIZE / 2;
    localparam int BALL_Y_START = SCREEN_H / 2 - BALL_SIZE / 2;
    localparam int PAD_Y_START  = SCREEN_H / 2 - PAD_H / 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } game_state_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pong_paddle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pong_paddle: one paddle; candidate y on tick, applied on commit.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pong_paddle
    import pong_pkg::*;
#(
    parameter int PADDLE_SPEED = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       dn,
    input  logic       tick,
    input  logic       commit,
    input  logic       freeze,
    output logic [8:0] y
);

    localparam logic signed [10:0] C_STEP  = 11'(PADDLE_SPEED);
    localparam logic signed [10:0] C_MIN   = 11'(PAD_Y_MIN);
    localparam logic signed [10:0] C_MAX   = 11'(PAD_Y_MAX);
    localparam logic [8:0]         C_START = 9'(PAD_Y_START);

    logic signed [10:0] w_raw;
    logic [8:0]         w_clamped;
    logic [8:0]         r_cand;

    always_comb begin
        w_raw = $signed({2'b00, y});
        if (up && !dn) begin
            w_raw = $signed({2'b00, y}) - C_STEP;
        end else if (dn && !up) begin
            w_raw = $signed({2'b00, y}) + C_STEP;
        end
        if (w_raw < C_MIN) begin
            w_clamped = C_MIN[8:0];
        end else if (w_raw > C_MAX) begin
            w_clamped = C_MAX[8:0];
        end else begin
            w_clamped = w_raw[8:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand <= C_START;
            y      <= C_START;
        end else begin
            if (tick) begin
                r_cand <= w_clamped;
            end
            if (commit && !freeze) begin
                y <= r_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pong_game_ctrl: per-frame Pong sequencing of paddles, ball and scoring.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_SPEED = 4,
    parameter int HOLD_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic       l_up,
    input  logic       l_dn,
    input  logic       r_up,
    input  logic       r_dn,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [8:0] pad_l_y,
    output logic [8:0] pad_r_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       upd_done
);

    localparam int HOLD_W      = ($clog2(HOLD_FRAMES + 1) > 6) ? $clog2(HOLD_FRAMES + 1) : 6;
    localparam int HOLD_LAST_I = (HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LAST_I);
    localparam logic [3:0]        WIN       = 4'(WIN_SCORE);

    localparam logic signed [10:0] C_BS    = 11'(BALL_SPEED);
    localparam logic signed [10:0] C_X_MIN = 11'(BALL_X_MIN);
    localparam logic signed [10:0] C_X_MAX = 11'(BALL_X_MAX);
    localparam logic signed [10:0] C_Y_MIN = 11'(BALL_Y_MIN);
    localparam logic signed [10:0] C_Y_MAX = 11'(BALL_Y_MAX);
    localparam logic signed [10:0] C_L_HIT = 11'(PAD_L_HIT_X);
    localparam logic signed [10:0] C_R_HIT = 11'(PAD_R_HIT_X);
    localparam logic [9:0]         C_X_CTR = 10'(BALL_X_START);
    localparam logic [8:0]         C_Y_CTR = 9'(BALL_Y_START);
    localparam logic [9:0]         C_BSZ   = 10'(BALL_SIZE);
    localparam logic [9:0]         C_PADH  = 10'(PAD_H);

    game_state_t        r_state;
    game_state_t        w_state_nxt;
    logic               r_tick;
    logic               r_calc;
    logic signed [10:0] r_cand_x;
    logic signed [10:0] r_cand_y;
    logic               r_dx_pos;
    logic               r_dy_pos;
    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic [9:0]         w_bx_nxt;
    logic [8:0]         w_by_nxt;
    logic               w_dx_nxt;
    logic               w_dy_nxt;
    logic [3:0]         w_sl_nxt;
    logic [3:0]         w_sr_nxt;
    logic               w_ovl_l;
    logic               w_ovl_r;
    logic signed [10:0] w_bx_s;
    logic signed [10:0] w_by_s;

    assign w_bx_s    = $signed({1'b0, ball_x});
    assign w_by_s    = $signed({2'b00, ball_y});
    assign game_over = (r_state == OVER);

    // Overlap uses the paddle positions still on screen, i.e. before this frame's move
    assign w_ovl_l = (({1'b0, ball_y} + C_BSZ) > {1'b0, pad_l_y}) &&
                     ({1'b0, ball_y} < ({1'b0, pad_l_y} + C_PADH));
    assign w_ovl_r = (({1'b0, ball_y} + C_BSZ) > {1'b0, pad_r_y}) &&
                     ({1'b0, ball_y} < ({1'b0, pad_r_y} + C_PADH));

    pong_paddle #(
        .PADDLE_SPEED(PADDLE_SPEED)
    ) u_pad_l (
        .clk   (clk),
        .reset (reset),
        .up    (l_up),
        .dn    (l_dn),
        .tick  (r_tick),
        .commit(r_calc),
        .freeze(r_state == OVER),
        .y     (pad_l_y)
    );

    pong_paddle #(
        .PADDLE_SPEED(PADDLE_SPEED)
    ) u_pad_r (
        .clk   (clk),
        .reset (reset),
        .up    (r_up),
        .dn    (r_dn),
        .tick  (r_tick),
        .commit(r_calc),
        .freeze(r_state == OVER),
        .y     (pad_r_y)
    );

    // Tick capture, candidate registration, then commit two edges after the tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick   <= 1'b0;
            r_calc   <= 1'b0;
            upd_done <= 1'b0;
            r_cand_x <= 11'sd0;
            r_cand_y <= 11'sd0;
        end else begin
            r_tick   <= frame_tick && !r_tick && !r_calc;
            r_calc   <= r_tick;
            upd_done <= r_calc;
            if (r_tick) begin
                r_cand_x <= r_dx_pos ? (w_bx_s + C_BS) : (w_bx_s - C_BS);
                r_cand_y <= r_dy_pos ? (w_by_s + C_BS) : (w_by_s - C_BS);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_hold   <= '0;
            ball_x   <= C_X_CTR;
            ball_y   <= C_Y_CTR;
            r_dx_pos <= 1'b1;
            r_dy_pos <= 1'b1;
            score_l  <= 4'd0;
            score_r  <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            ball_x   <= w_bx_nxt;
            ball_y   <= w_by_nxt;
            r_dx_pos <= w_dx_nxt;
            r_dy_pos <= w_dy_nxt;
            score_l  <= w_sl_nxt;
            score_r  <= w_sr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_bx_nxt    = ball_x;
        w_by_nxt    = ball_y;
        w_dx_nxt    = r_dx_pos;
        w_dy_nxt    = r_dy_pos;
        w_sl_nxt    = score_l;
        w_sr_nxt    = score_r;
        case (r_state)
            IDLE: begin
                if (serve) begin
                    w_state_nxt = SERVE;
                    w_hold_nxt  = '0;
                end
            end
            SERVE: begin
                if (r_calc) begin
                    if (r_hold >= HOLD_LAST) begin
                        w_state_nxt = PLAY;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold + HOLD_W'(1);
                    end
                end
            end
            PLAY: begin
                if (r_calc) begin
                    if (r_cand_y <= C_Y_MIN) begin
                        w_by_nxt = C_Y_MIN[8:0];
                        w_dy_nxt = 1'b1;
                    end else if (r_cand_y >= C_Y_MAX) begin
                        w_by_nxt = C_Y_MAX[8:0];
                        w_dy_nxt = 1'b0;
                    end else begin
                        w_by_nxt = r_cand_y[8:0];
                    end
                    // The ball already travels toward the loser, so dx needs no change on a point
                    if (!r_dx_pos) begin
                        if ((r_cand_x <= C_L_HIT) && w_ovl_l) begin
                            w_bx_nxt = C_L_HIT[9:0];
                            w_dx_nxt = 1'b1;
                        end else if (r_cand_x <= C_X_MIN) begin
                            w_bx_nxt    = C_X_MIN[9:0];
                            w_sr_nxt    = sat_inc(score_r, WIN);
                            w_state_nxt = POINT;
                            w_hold_nxt  = '0;
                        end else begin
                            w_bx_nxt = r_cand_x[9:0];
                        end
                    end else begin
                        if ((r_cand_x >= C_R_HIT) && w_ovl_r) begin
                            w_bx_nxt = C_R_HIT[9:0];
                            w_dx_nxt = 1'b0;
                        end else if (r_cand_x >= C_X_MAX) begin
                            w_bx_nxt    = C_X_MAX[9:0];
                            w_sl_nxt    = sat_inc(score_l, WIN);
                            w_state_nxt = POINT;
                            w_hold_nxt  = '0;
                        end else begin
                            w_bx_nxt = r_cand_x[9:0];
                        end
                    end
                end
            end
            POINT: begin
                if (r_calc) begin
                    if (r_hold >= HOLD_LAST) begin
                        w_hold_nxt = '0;
                        if ((score_l == WIN) || (score_r == WIN)) begin
                            w_state_nxt = OVER;
                        end else begin
                            w_state_nxt = SERVE;
                            w_bx_nxt    = C_X_CTR;
                            w_by_nxt    = C_Y_CTR;
                        end
                    end else begin
                        w_hold_nxt = r_hold + HOLD_W'(1);
                    end
                end
            end
            OVER: begin
                if (serve) begin
                    w_state_nxt = IDLE;
                    w_sl_nxt    = 4'd0;
                    w_sr_nxt    = 4'd0;
                    w_bx_nxt    = C_X_CTR;
                    w_by_nxt    = C_Y_CTR;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Frame-rate game controller for the VGA Pong design. Once per video frame it sequences paddle movement, ball motion, wall/paddle collision, scoring and serve/point/game-over flow. The renderer reads its outputs, so positions change only in vertical blanking. It sits between the 25 MHz pixel-clock domain's frame tick and the pixel-compare logic that draws the border, paddles and ball.

## Interface
- `WIN_SCORE`, default 7: points that end the game (1..15).
- `BALL_SPEED`, default 2: ball pixels per frame on each axis (1..7).
- `PADDLE_SPEED`, default 4: paddle pixels per frame (1..15).
- `HOLD_FRAMES`, default 60: frames the ball stays frozen before a serve.
- `clk` in 1: pixel clock.
- `reset` in 1: asynchronous reset, active-high.
- `frame_tick` in 1: one-cycle pulse at start of vertical blanking.
- `serve` in 1: start or restart request, level, sampled on clk.
- `l_up`, `l_dn`, `r_up`, `r_dn` in 1 each: debounced, synchronous paddle buttons.
- `ball_x` out 10: ball top-left x.
- `ball_y` out 9: ball top-left y.
- `pad_l_y`, `pad_r_y` out 9 each: paddle top y.
- `score_l`, `score_r` out 4 each: player scores.
- `game_over` out 1: high in OVER.
- `upd_done` out 1: one-cycle pulse when a frame update commits.

## Operation
- Geometry: 640x480 screen, 8 px border.
  - Ball is 8x8.
  - Paddles are 8 wide x 64 tall. Left paddle occupies x 16..23; right paddle occupies x 616..623.
  - Legal paddle top range: 8..408. Legal ball y range: 8..464.
- States:
  - IDLE: ball centred at (316,236). Scores are 0. `serve`=1 → SERVE.
  - SERVE: the hold counter counts `HOLD_FRAMES` ticks, then → PLAY.
  - PLAY: ball moves.
  - POINT: ball frozen for `HOLD_FRAMES` ticks. Then, if either score == `WIN_SCORE` → OVER; else re-centre the ball → SERVE.
  - OVER: everything frozen. `serve`=1 → IDLE with scores cleared.
- Paddles update on every `frame_tick` in all states except OVER.
  - up only: subtract `PADDLE_SPEED`. down only: add `PADDLE_SPEED`. Both or neither: hold.
  - Result is clamped to 8..408.
- Ball in PLAY: compute the next position using signed 11-bit math; no wrap is allowed.
  - Vertical: next y ≤ 8 → y=8, dy=+. Next y ≥ 464 → y=464, dy=−.
  - Left side (dx=−): if next x ≤ 24 and the ball overlaps the left paddle vertically (ball_y+8 > pad_l_y and ball_y < pad_l_y+64) → x=24, dx=+.
    - Else if next x ≤ 8 → x=8, `score_r`+1, → POINT.
  - Right side (dx=+) mirrors this: next x ≥ 608 with overlap → x=608, dx=−. Else next x ≥ 624 → x=624, `score_l`+1, → POINT.
  - Overlap tests use the paddle positions from before this frame's paddle move.
- Serve direction:
  - Reset: dx=+, dy=+.
  - After a point: dx points toward the player who lost the point; dy is kept.
- Scores saturate at `WIN_SCORE`.

## Timing
- Reset values:
  - State IDLE.
  - `ball_x`=316, `ball_y`=236.
  - `pad_l_y`=`pad_r_y`=208.
  - Scores 0, dx=+, dy=+.
  - `game_over`=0, `upd_done`=0.
- Frame update is a 2-cycle pipeline. `frame_tick` is sampled at edge T.
  - T+1: candidate positions are registered (CALC).
  - T+2: collisions are resolved and all outputs plus state commit together; `upd_done`=1 for this cycle only.
- Outputs are never partially updated: all position and score outputs change on the same edge.
- A `frame_tick` arriving while CALC is in progress is ignored.
- `serve` is acted on only in IDLE/OVER, at any cycle, not just at frame ticks.
- Reset asserted mid-update aborts the update and restores all reset values. There is no commit afterward.
- Simultaneous vertical and horizontal events in one frame: both are applied.
  - A corner paddle hit reflects both dx and dy.
  - A score event still freezes the ball at the clamped position.

## Structure
- `pong_pkg`:
  - Screen/border/paddle/ball geometry localparams.
  - Centre and start constants.
  - `game_state_t` enum {IDLE, SERVE, PLAY, POINT, OVER}.
- Sub-module `pong_paddle` (parameter `PADDLE_SPEED`): up/dn/tick/freeze in, clamped 9-bit y out. Instantiated twice.
- Top-level FSM, hold counter (6+ bits, sized from `HOLD_FRAMES`), ball datapath and score registers live in `pong_game_ctrl`.

## Test plan
- Reset, then hold `l_up` for 60 ticks → `pad_l_y` is 208, 204, …, clamps at 8 and stays 8. `pad_r_y`=208 throughout.
- `serve` in IDLE, `HOLD_FRAMES`=2 → ball stays at (316,236) for 2 ticks, then moves (+2,+2) per tick. `upd_done` fires exactly 2 cycles after each tick.
- Ball at y=462, dy=+ → next commit y=464, dy=−. The following tick gives y=462.
- Ball at (26,220), dx=−, `pad_l_y`=200 → x=24, dx=+, no score change.
  - Same case with `pad_l_y`=300 → ball reaches x=8, `score_r`=1, state POINT, ball frozen for `HOLD_FRAMES` ticks, then re-centred with dx=−.
- `WIN_SCORE`=1: first point → OVER after hold, `game_over`=1, paddles frozen under button presses. `serve` → IDLE with scores 0.
- Assert `reset` on the cycle after a `frame_tick` → no `upd_done`, all outputs at reset values next cycle.
